// File: rtl/t_pulse_pkg.sv
// t_pulse_pkg: shared debouncer state type and parameter defaults
package t_pulse_pkg;
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} deb_state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: reset-to-zero shift-register synchroniser for one asynchronous input
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/t_pulse_debouncer.sv
// t_pulse_debouncer: synchronise and debounce a button into a level and a one-cycle t pulse (define T_PULSE_BOTH_EDGES_EN to also pulse on release)
module t_pulse_debouncer
  import t_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic t,
  output logic busy
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s;
  deb_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic level_n, t_n;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(btn_in), .q(s));
  always_comb begin
    state_n = state;
    cnt_n = '0;
    level_n = btn_level;
    t_n = 1'b0;
    case (state)
      IDLE_LOW: if (s) begin
        state_n = WAIT_HIGH;
        cnt_n = CNT_W'(1);
      end
      WAIT_HIGH: if (!s) state_n = IDLE_LOW;
      else if (cnt == LAST) begin
        state_n = IDLE_HIGH;
        level_n = 1'b1;
        t_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      IDLE_HIGH: if (!s) begin
        state_n = WAIT_LOW;
        cnt_n = CNT_W'(1);
      end
      WAIT_LOW: if (s) state_n = IDLE_HIGH;
      else if (cnt == LAST) begin
        state_n = IDLE_LOW;
        level_n = 1'b0;
`ifdef T_PULSE_BOTH_EDGES_EN
        t_n = 1'b1;
`else
        t_n = 1'b0;
`endif
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE_LOW;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE_LOW;
      cnt <= '0;
      btn_level <= 1'b0;
      t <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      btn_level <= level_n;
      t <= t_n;
    end
  assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);
endmodule

// File: tb/tb_t_pulse_debouncer.sv
// tb_t_pulse_debouncer: random and directed stimulus against a sliding-window debounce model
module tb_t_pulse_debouncer;
  localparam int SS = 2;
  localparam int DC = 4;
`ifdef T_PULSE_BOTH_EDGES_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, t, busy;
  t_pulse_debouncer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .t(t), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  bit q_in[$];
  logic [DC-1:0] win;
  logic lvl, mt, prev_t, prev_lvl, tq, busy_seen;
  int edges, t_edge, lvl_edge, tcount;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q_in.delete();
    for (int i = 0; i < SS; i++) q_in.push_back(1'b0);
    win = '0;
    lvl = 1'b0;
    mt = 1'b0;
    prev_t = 1'b0;
    prev_lvl = 1'b0;
    edges = 0;
    t_edge = -1;
    lvl_edge = -1;
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_level"}, btn_level, 0);
    check({tag, "_t"}, t, 0);
    check({tag, "_busy"}, busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // The FSM sees btn_in delayed by SS edges; a level change is accepted once
  // the last DC seen samples all disagree with the current debounced level.
  task automatic step(input logic b);
    bit s;
    btn_in = b;
    @(posedge clk);
    edges++;
    s = q_in.pop_front();
    q_in.push_back(b);
    win = {win[DC-2:0], s};
    mt = 1'b0;
    if (win == {DC{~lvl}}) begin
      lvl = ~lvl;
      mt = lvl ? 1'b1 : BOTH;
    end
    #1;
    check("level", btn_level, lvl);
    check("t", t, mt);
    check("busy", busy, s != lvl);
    check("t_double", prev_t & t, 0);
    if (t) begin
      tq = ~tq;
      tcount++;
      t_edge = edges;
    end
    if (btn_level !== prev_lvl) lvl_edge = edges;
    if (busy) busy_seen = 1'b1;
    prev_t = t;
    prev_lvl = btn_level;
  endtask
  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask
  initial begin
    int c0;
    tq = 1'b0;
    tcount = 0;
    busy_seen = 1'b0;
    do_reset("rst0");
    hold(1'b1, 7);
    check("press_latency", t_edge, 6);
    check("press_level_edge", lvl_edge, 6);
    hold(1'b0, 10);
    c0 = tcount;
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
    check("bounce_no_t", tcount - c0, 0);
    edges = 0;
    t_edge = -1;
    hold(1'b1, 8);
    check("bounce_final_latency", t_edge, 6);
    c0 = tcount;
    busy_seen = 1'b0;
    hold(1'b0, 3);
    hold(1'b1, 8);
    check("glitch_level", btn_level, 1);
    check("glitch_no_t", tcount - c0, 0);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", busy, 0);
    c0 = tcount;
    edges = 0;
    lvl_edge = -1;
    hold(1'b0, 8);
    check("release_t_count", tcount - c0, BOTH ? 1 : 0);
    check("release_latency", lvl_edge, 6);
    do_reset("rst1");
    hold(1'b1, 4);
    rst_n = 1'b0;
    #2;
    check("midrst_level", btn_level, 0);
    check("midrst_t", t, 0);
    check("midrst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 8);
    check("midrst_repress", t_edge, 6);
    do_reset("rst2");
    for (int k = 0; k < 60; k++) hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * DC + 2));
    hold(1'b0, 10);
    do_reset("rst3");
    tq = 1'b0;
    c0 = tcount;
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    check("trigger_pulses", tcount - c0, BOTH ? 10 : 5);
    check("trigger_q", tq, BOTH ? 0 : 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
